// File: rtl/barrier_scheduler.sv
// Game-level sequencer for the barrier datapath: spawn timing, lane choice, lives, score and
// game-over, all paced by the VGA frame tick.
module barrier_scheduler #(
    parameter int unsigned LIVES_INIT      = 3,
    parameter int unsigned GAP_FRAMES      = 60,
    parameter int unsigned TRAVEL_FRAMES   = 120,
    parameter int unsigned HIT_HOLD_FRAMES = 30,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_v_sync,
    input  logic        i_start,
    input  logic        i_penguin_hit,
    output logic [1:0]  o_active,
    output logic [1:0]  o_lives,
    output logic [15:0] o_score,
    output logic        o_game_over
);

    typedef enum logic [2:0] {StIdle, StGap, StActive, StHit, StOver} state_e;

    localparam logic [1:0] LivesInit  = 2'(LIVES_INIT);
    localparam logic [7:0] GapLast    = 8'(GAP_FRAMES - 1);
    localparam logic [7:0] TravelLast = 8'(TRAVEL_FRAMES - 1);
    localparam logic [7:0] HoldLast   = 8'(HIT_HOLD_FRAMES - 1);

    state_e      state_q;
    logic        v_sync_q;
    logic [7:0]  cnt_q;
    logic [15:0] lfsr_q;
    logic        tick;
    logic [15:0] lfsr_next;
    logic [1:0]  lane;

    assign tick      = i_v_sync & ~v_sync_q;
    // Right-shifting Galois form of x^16+x^14+x^13+x^11.
    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    // Lane 00 would mean "no barrier", so fold it onto the middle lane.
    assign lane      = (lfsr_q[1:0] == 2'b00) ? 2'b10 : lfsr_q[1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            v_sync_q    <= 1'b0;
            cnt_q       <= 8'd0;
            lfsr_q      <= LFSR_SEED;
            o_active    <= 2'b00;
            o_lives     <= LivesInit;
            o_score     <= 16'd0;
            o_game_over <= 1'b0;
        end else begin
            v_sync_q <= i_v_sync;
            lfsr_q   <= lfsr_next;
            if (tick) begin
                cnt_q <= cnt_q + 8'd1;
            end
            // Any state change below also clears cnt_q, overriding the increment above.
            unique case (state_q)
                StIdle, StOver: begin
                    if (i_start) begin
                        state_q     <= StGap;
                        cnt_q       <= 8'd0;
                        o_lives     <= LivesInit;
                        o_score     <= 16'd0;
                        o_game_over <= 1'b0;
                    end
                end
                StGap: begin
                    if (tick && cnt_q == GapLast) begin
                        state_q  <= StActive;
                        cnt_q    <= 8'd0;
                        o_active <= lane;
                    end
                end
                StActive: begin
                    if (i_penguin_hit) begin
                        state_q  <= StHit;
                        cnt_q    <= 8'd0;
                        o_active <= 2'b00;
                        o_lives  <= (o_lives == 2'd0) ? 2'd0 : o_lives - 2'd1;
                    end else if (tick && cnt_q == TravelLast) begin
                        state_q  <= StGap;
                        cnt_q    <= 8'd0;
                        o_active <= 2'b00;
                        o_score  <= (o_score == 16'hFFFF) ? o_score : o_score + 16'd1;
                    end
                end
                StHit: begin
                    if (tick && cnt_q == HoldLast) begin
                        cnt_q <= 8'd0;
                        if (o_lives == 2'd0) begin
                            state_q     <= StOver;
                            o_game_over <= 1'b1;
                        end else begin
                            state_q <= StGap;
                        end
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    cnt_q    <= 8'd0;
                    o_active <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrier_scheduler.sv
// Directed bench for barrier_scheduler with a frame-countdown reference model checked every cycle.
module tb_barrier_scheduler;

    localparam int LIVES  = 3;
    localparam int GAP    = 60;
    localparam int TRAVEL = 120;
    localparam int HOLD   = 30;
    localparam int SEED   = 'hACE1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vs;
    logic        start;
    logic        hit;
    logic [1:0]  active;
    logic [1:0]  lives;
    logic [15:0] score;
    logic        game_over;

    int n_checks = 0;
    int n_fail   = 0;

    barrier_scheduler #(
        .LIVES_INIT     (LIVES),
        .GAP_FRAMES     (GAP),
        .TRAVEL_FRAMES  (TRAVEL),
        .HIT_HOLD_FRAMES(HOLD),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_v_sync     (vs),
        .i_start      (start),
        .i_penguin_hit(hit),
        .o_active     (active),
        .o_lives      (lives),
        .o_score      (score),
        .o_game_over  (game_over)
    );

    always #5 clk = ~clk;

    // Reference model: phase name plus frames left in that phase.
    localparam int PIdle = 0, PGap = 1, PActive = 2, PHit = 3, POver = 4;
    int m_phase, m_left, m_lane, m_lives, m_score, m_go, m_vs_prev, m_lfsr;

    function automatic void m_reset();
        m_phase = PIdle; m_left = 0; m_lane = 0; m_lives = LIVES;
        m_score = 0; m_go = 0; m_vs_prev = 0; m_lfsr = SEED;
    endfunction

    function automatic int pick_lane(input int r);
        int l;
        l = r % 4;
        return (l == 0) ? 2 : l;
    endfunction

    function automatic void m_step(input int v, input int s, input int h);
        bit tk;
        tk = (v != 0) && (m_vs_prev == 0);
        m_vs_prev = v;
        case (m_phase)
            PIdle, POver: if (s != 0) begin
                m_phase = PGap; m_left = GAP; m_lives = LIVES; m_score = 0; m_go = 0;
            end
            PGap: if (tk) begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = PActive; m_left = TRAVEL; m_lane = pick_lane(m_lfsr);
                end
            end
            PActive: begin
                if (h != 0) begin
                    m_phase = PHit; m_left = HOLD; m_lane = 0;
                    if (m_lives > 0) m_lives--;
                end else if (tk) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = PGap; m_left = GAP; m_lane = 0;
                        if (m_score < 65535) m_score++;
                    end
                end
            end
            PHit: if (tk) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_lives == 0) begin
                        m_phase = POver; m_go = 1;
                    end else begin
                        m_phase = PGap; m_left = GAP;
                    end
                end
            end
            default: m_phase = PIdle;
        endcase
        m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'hB400 : 0);
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step(int'(vs), int'(start), int'(hit));
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                n_checks++;
                if (int'(active) != m_lane || int'(lives) != m_lives ||
                    int'(score) != m_score || int'(game_over) != m_go) begin
                    n_fail++;
                    $display("FAIL model_compare t=%0t got active=%0d lives=%0d score=%0d go=%0d expected active=%0d lives=%0d score=%0d go=%0d",
                             $time, active, lives, score, game_over, m_lane, m_lives, m_score,
                             m_go);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_nz(input string name, input int act);
        n_checks++;
        if (act == 0) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=nonzero", name, act);
        end
    endtask

    // Each task starts and ends just after a falling clock edge.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            vs = 1'b1; @(negedge clk); @(negedge clk);
            vs = 1'b0; @(negedge clk); @(negedge clk);
        end
    endtask

    task automatic tick_edge();
        vs = 1'b1; @(negedge clk);
    endtask

    task automatic finish_frame();
        @(negedge clk); vs = 1'b0; @(negedge clk); @(negedge clk);
    endtask

    task automatic pulse_hit();
        hit = 1'b1; @(negedge clk); hit = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; vs = 1'b0; start = 1'b0; hit = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_active", int'(active), 0);
        chk("reset_lives", int'(lives), 3);
        chk("reset_score", int'(score), 0);
        chk("reset_game_over", int'(game_over), 0);
        rst_n = 1'b1;
        frames(3);
        chk("idle_no_spawn", int'(active), 0);

        // First spawn after GAP frames.
        pulse_start();
        frames(GAP - 1);
        chk("gap_before_spawn", int'(active), 0);
        tick_edge();
        chk_nz("first_spawn_lane", int'(active));
        finish_frame();

        // Dodge: barrier clears after TRAVEL frames and scores.
        frames(TRAVEL - 1);
        chk_nz("still_travelling", int'(active));
        chk("score_before_dodge", int'(score), 0);
        tick_edge();
        chk("dodge_clears_lane", int'(active), 0);
        chk("dodge_scores", int'(score), 1);
        finish_frame();
        frames(GAP - 1);
        tick_edge();
        chk_nz("second_spawn_lane", int'(active));
        finish_frame();

        // Single-cycle hit.
        frames(5);
        pulse_hit();
        chk("hit_lives_3_to_2", int'(lives), 2);
        chk("hit_clears_lane", int'(active), 0);
        frames(HOLD - 1);
        chk("hold_no_game_over", int'(game_over), 0);
        frames(1);
        frames(GAP - 1);
        tick_edge();
        chk_nz("spawn_after_hold", int'(active));
        finish_frame();

        // Lose remaining lives and restart.
        pulse_hit();
        chk("hit_lives_2_to_1", int'(lives), 1);
        frames(HOLD);
        frames(GAP - 1);
        tick_edge();
        finish_frame();
        pulse_hit();
        chk("hit_lives_1_to_0", int'(lives), 0);
        frames(HOLD - 1);
        chk("not_over_before_hold_end", int'(game_over), 0);
        tick_edge();
        chk("game_over_set", int'(game_over), 1);
        finish_frame();
        chk("over_score_held", int'(score), 1);
        pulse_hit();
        chk("hit_ignored_in_over", int'(lives), 0);
        pulse_start();
        chk("restart_lives", int'(lives), 3);
        chk("restart_score", int'(score), 0);
        chk("restart_clears_over", int'(game_over), 0);

        // Hit coincident with the final travel tick, held for five clocks.
        frames(GAP);
        frames(TRAVEL);
        chk("dodge_after_restart", int'(score), 1);
        frames(GAP);
        frames(TRAVEL - 1);
        vs = 1'b1; hit = 1'b1;
        @(negedge clk);
        chk("coincident_hit_lives", int'(lives), 2);
        chk("coincident_hit_no_score", int'(score), 1);
        chk("coincident_hit_lane", int'(active), 0);
        repeat (4) @(negedge clk);
        hit = 1'b0;
        vs = 1'b0; @(negedge clk); @(negedge clk);
        chk("long_hit_single_decrement", int'(lives), 2);

        // Hit still high across HIT->GAP has no effect.
        frames(HOLD - 1);
        hit = 1'b1;
        tick_edge();
        repeat (3) @(negedge clk);
        hit = 1'b0;
        chk("stale_hit_ignored", int'(lives), 2);
        vs = 1'b0; @(negedge clk); @(negedge clk);

        // Asynchronous reset mid-ACTIVE.
        frames(GAP - 1);
        tick_edge();
        chk_nz("spawn_before_reset", int'(active));
        finish_frame();
        frames(3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_active", int'(active), 0);
        chk("async_reset_lives", int'(lives), 3);
        chk("async_reset_score", int'(score), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        frames(GAP - 1);
        tick_edge();
        chk_nz("spawn_after_reset", int'(active));
        finish_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
